prbs_checker: RTL

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker_if.sv | 14 +
 rtl/prbs_checker.sv | 114 +++++++++++
 2 files changed

// File: rtl/prbs_checker_if.sv
// Serial PRBS receive-side bundle: received bit stream in, lock/error status out.
interface prbs_checker_if;
    logic        DIN;
    logic        DIN_VALID;
    logic        CLR_CNT;
    logic        LOCKED;
    logic        ERR;
    logic [15:0] ERR_CNT;

    // Valid-only stream with no ready: the checker accepts DIN on every clock where DIN_VALID=1
    // and ignores DIN otherwise; there is no backpressure path.
    modport master (output DIN, DIN_VALID, CLR_CNT, input LOCKED, ERR, ERR_CNT);
    modport slave  (input DIN, DIN_VALID, CLR_CNT, output LOCKED, ERR, ERR_CNT);
endinterface

// File: rtl/prbs_checker.sv
// PRBS receive checker: seeds from the line, hunts for a run of correct predictions,
// then free-runs its own predictor and counts bit errors while locked.
module prbs_checker #(
    parameter int N          = 3,
    parameter int FB_TAP     = 2,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    prbs_checker_if.slave bus,
    output logic [1:0]    dbg_state
);
    localparam int FW = $clog2(N + 1);

    typedef enum logic [1:0] {
        SEED = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t        state;
    logic [N:1]    sr;
    logic [FW-1:0] fill;
    logic [7:0]    match_cnt;
    logic [7:0]    miss_cnt;
    logic          locked_q;
    logic          err_q;
    logic [15:0]   err_cnt_q;

    logic          pred;
    logic [N:1]    sr_din;
    logic [N:1]    sr_pred;

    assign pred    = sr[N] ~^ sr[FB_TAP];
    assign sr_din  = {sr[N-1:1], bus.DIN};
    // While locked the predictor feeds itself, so one line error cannot corrupt later predictions.
    assign sr_pred = {sr[N-1:1], pred};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= SEED;
            sr        <= '0;
            fill      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (bus.DIN_VALID) begin
                case (state)
                    SEED: begin
                        sr <= sr_din;
                        if (fill == FW'(N - 1)) begin
                            fill <= '0;
                            // An all-ones fill is the XNOR lock-up state; refill instead of hunting.
                            if (sr_din != '1) begin
                                state     <= HUNT;
                                match_cnt <= '0;
                            end
                        end else begin
                            fill <= fill + FW'(1);
                        end
                    end
                    HUNT: begin
                        sr <= sr_din;
                        if (bus.DIN == pred) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (match_cnt == 8'(LOCK_CNT - 1)) begin
                                state    <= LOCK;
                                locked_q <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        sr <= sr_pred;
                        if (bus.DIN != pred) begin
                            err_q    <= 1'b1;
                            miss_cnt <= miss_cnt + 8'd1;
                            if (err_cnt_q != 16'hFFFF)
                                err_cnt_q <= err_cnt_q + 16'd1;
                            if (miss_cnt == 8'(UNLOCK_CNT - 1)) begin
                                state    <= SEED;
                                locked_q <= 1'b0;
                                fill     <= '0;
                                miss_cnt <= '0;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= SEED;
                        locked_q <= 1'b0;
                        fill     <= '0;
                    end
                endcase
            end
            // Clear wins over an increment landing in the same cycle.
            if (bus.CLR_CNT)
                err_cnt_q <= '0;
        end
    end

    assign bus.LOCKED  = locked_q;
    assign bus.ERR     = err_q;
    assign bus.ERR_CNT = err_cnt_q;
    assign dbg_state   = state;
endmodule
